// File: rtl/bus_register_counter_if.sv
// Bus-side signals of bus_register_counter: source slices with load requests,
// and output slices with their drive enables.
interface bus_register_counter_if #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned INPUT_COUNT  = 2,
    parameter int unsigned OUTPUT_COUNT = 2
);
    logic [WIDTH*INPUT_COUNT-1:0]  busInputs;
    logic [INPUT_COUNT-1:0]        busReadEnable;
    logic [OUTPUT_COUNT-1:0]       busWriteEnable;
    logic [WIDTH*OUTPUT_COUNT-1:0] busOutputs;

    modport master (
        output busInputs,
        output busReadEnable,
        output busWriteEnable,
        input  busOutputs
    );

    modport slave (
        input  busInputs,
        input  busReadEnable,
        input  busWriteEnable,
        output busOutputs
    );
endinterface

// File: rtl/bus_register_counter.sv
// Bus-loadable datapath register with increment/decrement, shift through carry,
// gated bus output slices and zero/negative status.
module bus_register_counter #(
    parameter int unsigned     WIDTH         = 8,
    parameter int unsigned     INPUT_COUNT   = 2,
    parameter int unsigned     OUTPUT_COUNT  = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0,
    parameter int unsigned     STEP          = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    bus_register_counter_if.slave   bus,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    shl,
    input  logic                    shr,
    input  logic                    carryIn,
    output logic [WIDTH-1:0]        value,
    output logic                    carryOut,
    output logic                    zero,
    output logic                    negative
);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic             load_any;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic             shl_carry;
    logic             shr_carry;

    // Ascending scan so the highest-indexed requesting source wins.
    always_comb begin
        load_val = '0;
        for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
            if (bus.busReadEnable[i]) begin
                load_val = bus.busInputs[WIDTH*i +: WIDTH];
            end
        end
    end

    assign load_any = |bus.busReadEnable;
    assign sum      = {1'b0, value} + {1'b0, STEP_W};
    assign diff     = {1'b0, value} - {1'b0, STEP_W};

    generate
        if (WIDTH == 1) begin : g_shift_narrow
            assign shl_val   = carryIn;
            assign shr_val   = carryIn;
            assign shl_carry = value[0];
            assign shr_carry = value[0];
        end else begin : g_shift_wide
            assign shl_val   = {value[WIDTH-2:0], carryIn};
            assign shr_val   = {carryIn, value[WIDTH-1:1]};
            assign shl_carry = value[WIDTH-1];
            assign shr_carry = value[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            value    <= DEFAULT_VALUE;
            carryOut <= 1'b0;
        end else if (load_any) begin
            value <= load_val;
        end else if (inc ^ dec) begin
            // diff[WIDTH] is the borrow out of the subtraction.
            if (inc) begin
                value    <= sum[WIDTH-1:0];
                carryOut <= sum[WIDTH];
            end else begin
                value    <= diff[WIDTH-1:0];
                carryOut <= diff[WIDTH];
            end
        end else if (shl ^ shr) begin
            if (shl) begin
                value    <= shl_val;
                carryOut <= shl_carry;
            end else begin
                value    <= shr_val;
                carryOut <= shr_carry;
            end
        end
    end

    always_comb begin
        bus.busOutputs = '0;
        for (int unsigned j = 0; j < OUTPUT_COUNT; j++) begin
            if (bus.busWriteEnable[j]) begin
                bus.busOutputs[WIDTH*j +: WIDTH] = value;
            end
        end
    end

    assign zero     = (value == '0);
    assign negative = value[WIDTH-1];
endmodule

// File: tb/tb_bus_register_counter.sv
// Scoreboard bench for bus_register_counter: two instances (DEFAULT_VALUE=FD/STEP=1
// and DEFAULT_VALUE=0/STEP=3) driven with shared stimulus.
module tb_bus_register_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, inc, dec, shl, shr, carryIn;
    logic [7:0] value_a, value_b;
    logic carry_a, carry_b, zero_a, zero_b, neg_a, neg_b;

    bus_register_counter_if #(.WIDTH(8), .INPUT_COUNT(2), .OUTPUT_COUNT(2)) bus_a ();
    bus_register_counter_if #(.WIDTH(8), .INPUT_COUNT(2), .OUTPUT_COUNT(2)) bus_b ();

    bus_register_counter #(
        .WIDTH(8), .INPUT_COUNT(2), .OUTPUT_COUNT(2), .DEFAULT_VALUE(8'hFD), .STEP(1)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .inc(inc), .dec(dec), .shl(shl),
        .shr(shr), .carryIn(carryIn), .value(value_a), .carryOut(carry_a),
        .zero(zero_a), .negative(neg_a)
    );

    bus_register_counter #(
        .WIDTH(8), .INPUT_COUNT(2), .OUTPUT_COUNT(2), .DEFAULT_VALUE(8'h00), .STEP(3)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .inc(inc), .dec(dec), .shl(shl),
        .shr(shr), .carryIn(carryIn), .value(value_b), .carryOut(carry_b),
        .zero(zero_b), .negative(neg_b)
    );

    typedef struct {
        logic [7:0] va;
        logic       ca;
        logic [7:0] vb;
        logic       cb;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] ma, mb;
    logic       mca, mcb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference next state, returned as {carry, value}.
    function automatic logic [8:0] model(input logic [7:0] v, input logic c, input logic r,
                                         input logic [15:0] bi, input logic [1:0] re,
                                         input logic i, input logic d, input logic sl,
                                         input logic sr, input logic ci,
                                         input logic [7:0] dflt, input int step);
        int t;
        if (r) return {1'b0, dflt};
        if (re[1]) return {c, bi[15:8]};
        if (re[0]) return {c, bi[7:0]};
        if (i && !d) begin
            t = int'(v) + step;
            return {t >= 256, 8'(t % 256)};
        end
        if (d && !i) begin
            t = int'(v) - step;
            if (t < 0) t += 256;
            return {int'(v) < step, 8'(t)};
        end
        if (sl && !sr) return {v[7], v[6:0], ci};
        if (sr && !sl) return {v[0], ci, v[7:1]};
        return {c, v};
    endfunction

    task automatic do_cycle(input logic r, input logic [15:0] bi, input logic [1:0] re,
                            input logic i, input logic d, input logic sl, input logic sr,
                            input logic ci);
        exp_t e;
        rst = r; inc = i; dec = d; shl = sl; shr = sr; carryIn = ci;
        bus_a.busInputs = bi; bus_a.busReadEnable = re;
        bus_b.busInputs = bi; bus_b.busReadEnable = re;
        {mca, ma} = model(ma, mca, r, bi, re, i, d, sl, sr, ci, 8'hFD, 1);
        {mcb, mb} = model(mb, mcb, r, bi, re, i, d, sl, sr, ci, 8'h00, 3);
        sb.push_back('{va: ma, ca: mca, vb: mb, cb: mcb});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("value_a", value_a, e.va);
        check("carry_a", carry_a, e.ca);
        check("zero_a", zero_a, e.va == 8'h00);
        check("neg_a", neg_a, e.va[7]);
        check("value_b", value_b, e.vb);
        check("carry_b", carry_b, e.cb);
        check("zero_b", zero_b, e.vb == 8'h00);
        check("neg_b", neg_b, e.vb[7]);
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] v);
        do_cycle(1'b0, {v, 8'h00}, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_outputs(input logic [1:0] we);
        bus_a.busWriteEnable = we;
        bus_b.busWriteEnable = we;
        #1;
        check("bus_out_a", bus_a.busOutputs, {we[1] ? ma : 8'h00, we[0] ? ma : 8'h00});
        check("bus_out_b", bus_b.busOutputs, {we[1] ? mb : 8'h00, we[0] ? mb : 8'h00});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; inc = 1'b0; dec = 1'b0; shl = 1'b0; shr = 1'b0; carryIn = 1'b0;
        bus_a.busInputs = '0; bus_a.busReadEnable = '0; bus_a.busWriteEnable = '0;
        bus_b.busInputs = '0; bus_b.busReadEnable = '0; bus_b.busWriteEnable = '0;
        ma = 'x; mb = 'x; mca = 'x; mcb = 'x;
        @(negedge clk);

        // Reset overrides load and increment
        do_cycle(1'b1, 16'hA53C, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_value", value_a, 8'hFD);
        check("rst_carry", carry_a, 1'b0);
        check("rst_zero", zero_a, 1'b0);
        check("rst_neg", neg_a, 1'b1);
        check("rst_value_b", value_b, 8'h00);

        // Load priority
        do_cycle(1'b0, 16'hA53C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("load_hi", value_a, 8'hA5);
        do_cycle(1'b0, 16'hA53C, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("load_lo", value_a, 8'h3C);
        do_cycle(1'b0, 16'hA53C, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("load_over_inc", value_a, 8'hA5);

        // Wrap on increment/decrement
        load(8'hFE);
        do_cycle(1'b0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("inc_ff", value_a, 8'hFF);
        check("inc_ff_c", carry_a, 1'b0);
        check("step3_wrap", value_b, 8'h01);
        check("step3_wrap_c", carry_b, 1'b1);
        do_cycle(1'b0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("inc_wrap", value_a, 8'h00);
        check("inc_wrap_c", carry_a, 1'b1);
        check("inc_wrap_z", zero_a, 1'b1);
        do_cycle(1'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("dec_borrow", value_a, 8'hFF);
        check("dec_borrow_c", carry_a, 1'b1);
        do_cycle(1'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("dec_fe", value_a, 8'hFE);
        check("dec_fe_c", carry_a, 1'b0);

        // Shifts through carry
        load(8'h81);
        do_cycle(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("shl", value_a, 8'h02);
        check("shl_c", carry_a, 1'b1);
        do_cycle(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("shr", value_a, 8'h81);
        check("shr_c", carry_a, 1'b0);
        do_cycle(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("shl_shr_hold", value_a, 8'h81);
        check("shl_shr_hold_c", carry_a, 1'b0);

        // Output gating
        load(8'h5A);
        check_outputs(2'b10);
        check("gate_10", bus_a.busOutputs, 16'h5A00);
        check_outputs(2'b11);
        check("gate_11", bus_a.busOutputs, 16'h5A5A);
        check_outputs(2'b00);
        check("gate_00", bus_a.busOutputs, 16'h0000);

        // inc+dec cancels and falls through to shift
        load(8'h40);
        do_cycle(1'b0, 16'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("conflict_shl", value_a, 8'h81);
        check("conflict_shl_c", carry_a, 1'b0);

        // Reset in the middle of an increment burst
        load(8'h10);
        do_cycle(1'b0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("burst1_b", value_b, 8'h13);
        check("burst1_a", value_a, 8'h11);
        do_cycle(1'b1, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("burst2_b", value_b, 8'h00);
        check("burst2_a", value_a, 8'hFD);
        do_cycle(1'b0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("burst3_b", value_b, 8'h03);
        do_cycle(1'b0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("burst4_b", value_b, 8'h06);
        check("burst4_a", value_a, 8'hFF);

        // Random mix
        for (int n = 0; n < 400; n++) begin
            do_cycle($urandom_range(0, 15) == 0, 16'($urandom),
                     ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (n % 8 == 0) check_outputs(2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
